// File: rtl/rule_table_loader_pkg.sv
// rule_table_loader_pkg: command, target, selector and FSM encodings for the rule-table loader
package rule_table_loader_pkg;
  localparam int CMD_ADDR_W = 19;
  localparam int CMD_DATA_W = 64;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_CLEAR = 2'd1, OP_SEL = 2'd2, OP_RSVD = 2'd3} op_e;
  typedef enum logic {TGT_REGEX = 1'b0, TGT_FW = 1'b1} tgt_e;
  localparam logic [31:0] SEL_BOTH  = 32'd0;
  localparam logic [31:0] SEL_REGEX = 32'd1;
  localparam logic [31:0] SEL_FW    = 32'd2;
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, SEL} state_e;
  typedef struct packed {
    op_e                   op;
    tgt_e                  tgt;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;
  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small show-ahead FIFO; head entry is visible on dout while not empty
module fallthrough_small_fifo #(
  parameter int WIDTH          = 86,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = MAX_DEPTH_BITS + 1;
  logic [WIDTH-1:0] mem [2**MAX_DEPTH_BITS];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {MAX_DEPTH_BITS{1'b0}}};
  assign dout = mem[rd_ptr[MAX_DEPTH_BITS-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[MAX_DEPTH_BITS-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
endmodule

// File: rtl/rule_table_loader.sv
// rule_table_loader: queues host table-update commands and sequences them onto the
// regex/firewall table write ports; also owns the output selector and a sticky error flag.
module rule_table_loader
  import rule_table_loader_pkg::*;
#(
  parameter int REGEX_ADDR_WIDTH    = 14,
  parameter int REGEX_DATA_WIDTH    = 15,
  parameter int REGEX_DEPTH         = 16384,
  parameter int FW_ADDR_WIDTH       = 19,
  parameter int FW_DATA_WIDTH       = 64,
  parameter int FW_DEPTH            = 512,
  parameter int CMD_FIFO_DEPTH_BITS = 2
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic                        cmd_target,
  input  logic [18:0]                 cmd_addr,
  input  logic [63:0]                 cmd_data,
  output logic [REGEX_DATA_WIDTH-1:0] regex_dout,
  output logic [REGEX_ADDR_WIDTH-1:0] regex_out_addr,
  output logic                        regex_wr_en,
  output logic [FW_DATA_WIDTH-1:0]    firewall_dout,
  output logic [FW_ADDR_WIDTH-1:0]    firewall_out_addr,
  output logic                        firewall_wr_en,
  output logic [31:0]                 output_selector,
  output logic                        busy,
  output logic [31:0]                 write_count,
  output logic                        err,
  input  logic                        err_clr
);
  localparam logic [CMD_ADDR_W:0]   RX_LIM  = (CMD_ADDR_W+1)'(REGEX_DEPTH);
  localparam logic [CMD_ADDR_W:0]   FW_LIM  = (CMD_ADDR_W+1)'(FW_DEPTH);
  localparam logic [CMD_ADDR_W-1:0] RX_LAST = CMD_ADDR_W'(REGEX_DEPTH - 1);
  localparam logic [CMD_ADDR_W-1:0] FW_LAST = CMD_ADDR_W'(FW_DEPTH - 1);
  state_e state, state_nx;
  cmd_t cmd_in, head, cmd_q;
  logic [CMD_W-1:0] fifo_dout;
  logic fifo_full, fifo_empty, pop, in_range, clr, rx_we, fw_we, err_set, sel_ld;
  logic [CMD_ADDR_W-1:0] cnt, last, wr_addr;
  logic [CMD_DATA_W-1:0] wr_data;
  assign cmd_in = {cmd_op, cmd_target, cmd_addr, cmd_data};
  assign head = cmd_t'(fifo_dout);
  assign cmd_ready = !fifo_full;
  assign busy = (state != IDLE) || !fifo_empty;
  assign pop = (state == IDLE) && !fifo_empty;
  assign last = (cmd_q.tgt == TGT_FW) ? FW_LAST : RX_LAST;
  assign in_range = (cmd_q.tgt == TGT_FW) ? ({1'b0, cmd_q.addr} < FW_LIM) : ({1'b0, cmd_q.addr} < RX_LIM);
  fallthrough_small_fifo #(
    .WIDTH(CMD_W),
    .MAX_DEPTH_BITS(CMD_FIFO_DEPTH_BITS)
  ) u_cmd_fifo (
    .clk  (axi_aclk),
    .rst_n(axi_aresetn),
    .din  (cmd_in),
    .wr_en(cmd_valid && cmd_ready),
    .rd_en(pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = !pop ? IDLE :
                 head.op == OP_WRITE ? WRITE :
                 head.op == OP_CLEAR ? CLEAR :
                 head.op == OP_SEL   ? SEL : IDLE;
    else if (state == CLEAR)
      state_nx = (cnt == last) ? IDLE : CLEAR;
  end
  // Strobes, address and data are computed here and registered below, so a
  // command popped in IDLE shows its first write one edge after entering WRITE/CLEAR.
  always_comb begin
    clr     = state == CLEAR;
    rx_we   = ((state == WRITE && in_range) || clr) && cmd_q.tgt == TGT_REGEX;
    fw_we   = ((state == WRITE && in_range) || clr) && cmd_q.tgt == TGT_FW;
    err_set = (state == WRITE && !in_range) || (pop && head.op == OP_RSVD);
    sel_ld  = state == SEL;
    wr_addr = clr ? cnt : cmd_q.addr;
    wr_data = clr ? '0 : cmd_q.data;
  end
  always_ff @(posedge axi_aclk or negedge axi_aresetn)
    if (!axi_aresetn) begin
      cmd_q             <= '0;
      cnt               <= '0;
      regex_wr_en       <= 1'b0;
      regex_out_addr    <= '0;
      regex_dout        <= '0;
      firewall_wr_en    <= 1'b0;
      firewall_out_addr <= '0;
      firewall_dout     <= '0;
      output_selector   <= SEL_BOTH;
      write_count       <= '0;
      err               <= 1'b0;
    end else begin
      if (pop) cmd_q <= head;
      cnt            <= clr ? cnt + CMD_ADDR_W'(1) : '0;
      regex_wr_en    <= rx_we;
      firewall_wr_en <= fw_we;
      if (rx_we) begin
        regex_out_addr <= wr_addr[REGEX_ADDR_WIDTH-1:0];
        regex_dout     <= wr_data[REGEX_DATA_WIDTH-1:0];
      end
      if (fw_we) begin
        firewall_out_addr <= wr_addr[FW_ADDR_WIDTH-1:0];
        firewall_dout     <= wr_data[FW_DATA_WIDTH-1:0];
      end
      if (sel_ld) output_selector <= cmd_q.data[31:0];
      if (rx_we || fw_we) write_count <= write_count + 32'd1;
      err <= err_set || (err && !err_clr);
    end
endmodule

// File: tb/tb_rule_table_loader.sv
// tb_rule_table_loader: directed stimulus against a write-list scoreboard for rule_table_loader
module tb_rule_table_loader;
  import rule_table_loader_pkg::*;
  localparam int RX_DEPTH = 16384;
  localparam int FW_DEPTH = 512;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_target, err_clr;
  logic [1:0] cmd_op;
  logic [18:0] cmd_addr;
  logic [63:0] cmd_data;
  logic [14:0] regex_dout;
  logic [13:0] regex_out_addr;
  logic regex_wr_en, firewall_wr_en, busy, err;
  logic [63:0] firewall_dout;
  logic [18:0] firewall_out_addr;
  logic [31:0] output_selector, write_count;
  always #5 clk = ~clk;
  rule_table_loader dut (
    .axi_aclk         (clk),
    .axi_aresetn      (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_target       (cmd_target),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .regex_dout       (regex_dout),
    .regex_out_addr   (regex_out_addr),
    .regex_wr_en      (regex_wr_en),
    .firewall_dout    (firewall_dout),
    .firewall_out_addr(firewall_out_addr),
    .firewall_wr_en   (firewall_wr_en),
    .output_selector  (output_selector),
    .busy             (busy),
    .write_count      (write_count),
    .err              (err),
    .err_clr          (err_clr)
  );
  typedef struct {
    bit          fw;
    int unsigned addr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int unsigned wc_exp = 0;
  bit chk_en = 1'b0;
  bit blocked = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask
  // Every accepted command expands into the list of table writes it must cause.
  function automatic void model_accept(input logic [1:0] op, input bit tgt, input int unsigned addr, input logic [63:0] data);
    int unsigned depth = tgt ? FW_DEPTH : RX_DEPTH;
    if (op == OP_WRITE && addr < depth) exp_q.push_back('{tgt, addr, data});
    else if (op == OP_CLEAR)
      for (int i = 0; i < int'(depth); i++) exp_q.push_back('{tgt, i, 64'h0});
  endfunction
  always @(negedge clk) if (chk_en) begin
    exp_t e;
    chk("strobe_exclusive", regex_wr_en & firewall_wr_en, 0);
    if (regex_wr_en | firewall_wr_en) begin
      wc_exp++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("write_target", firewall_wr_en, e.fw);
        if (e.fw) begin
          chk("fw_addr", firewall_out_addr, e.addr);
          chk("fw_data", firewall_dout, e.data);
        end else begin
          chk("rx_addr", regex_out_addr, e.addr[13:0]);
          chk("rx_data", regex_dout, e.data[14:0]);
        end
      end
    end
    chk("write_count", write_count, wc_exp);
  end
  task automatic send(input logic [1:0] op, input bit tgt, input int unsigned addr, input logic [63:0] data);
    bit ok;
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt; cmd_addr = addr[18:0]; cmd_data = data;
    forever begin
      ok = cmd_ready;
      @(posedge clk);
      if (ok) break;
      blocked = 1'b1;
      n++;
      if (n > 5000) begin chk("send_timeout", 0, 1); break; end
      @(negedge clk);
    end
    if (ok) model_accept(op, tgt, addr, data);
  endtask
  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 20000 && busy; n++) @(negedge clk);
    chk("drain_busy", busy, 0);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    int run;
    cmd_valid = 0; cmd_op = 0; cmd_target = 0; cmd_addr = 0; cmd_data = 0; err_clr = 0;
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regex_wr_en", regex_wr_en, 0);
    chk("rst_fw_wr_en", firewall_wr_en, 0);
    chk("rst_regex_addr", regex_out_addr, 0);
    chk("rst_fw_dout", firewall_dout, 0);
    chk("rst_selector", output_selector, SEL_BOTH);
    chk("rst_write_count", write_count, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk_en = 1'b1;
    // single regex write: strobe visible two edges after acceptance, for one cycle
    send(OP_WRITE, TGT_REGEX, 'h0123, 64'h5A5A);
    idle();
    chk("t1_lat_a", regex_wr_en, 0);
    @(negedge clk);
    chk("t1_lat_b", regex_wr_en, 0);
    @(negedge clk);
    chk("t1_strobe", regex_wr_en, 1);
    chk("t1_addr", regex_out_addr, 'h0123);
    chk("t1_data", regex_dout, 'h5A5A);
    chk("t1_wc", write_count, 1);
    chk("t1_fw_quiet", firewall_wr_en, 0);
    @(negedge clk);
    chk("t1_one_cycle", regex_wr_en, 0);
    chk("t1_addr_hold", regex_out_addr, 'h0123);
    // out-of-range firewall write, then err_clr; then error vs clear priority
    send(OP_WRITE, TGT_FW, 600, 64'hDEAD);
    idle();
    repeat (3) @(negedge clk);
    chk("t2_err_set", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_err_cleared", err, 0);
    send(OP_RSVD, TGT_REGEX, 0, 64'h0);
    idle();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_err_wins", err, 1);
    chk("t2_rsvd_idle", busy, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t2_err_cleared2", err, 0);
    // firewall clear: 512 consecutive strobes, busy gone once they stop
    send(OP_CLEAR, TGT_FW, 0, 64'h0);
    idle();
    for (int n = 0; n < 10 && !firewall_wr_en; n++) @(negedge clk);
    run = 0;
    while (firewall_wr_en && run < 600) begin
      run++;
      @(negedge clk);
    end
    chk("t3_run_len", run, 512);
    chk("t3_busy_drop", busy, 0);
    chk("t3_wc", write_count, 513);
    // six writes behind a clear: FIFO fills, ready drops, all written in order
    blocked = 1'b0;
    send(OP_CLEAR, TGT_FW, 0, 64'h0);
    send(OP_WRITE, TGT_FW, 0, 64'h0123_4567_89AB_CDEF);
    send(OP_WRITE, TGT_REGEX, 16383, 64'hFFFF_FFFF_FFFF_8001);
    send(OP_WRITE, TGT_FW, 511, 64'hFFFF_0000_FFFF_0000);
    send(OP_WRITE, TGT_REGEX, 'h2AAA, 64'h0000_0000_0000_2AAA);
    send(OP_WRITE, TGT_FW, 5, 64'h8000_0000_0000_0001);
    send(OP_WRITE, TGT_REGEX, 7, 64'h0000_0000_0000_7FFF);
    idle();
    wait_idle();
    chk("t4_ready_dropped", blocked, 1);
    chk("t4_wc", write_count, 1031);
    chk("t4_last_rx_data", regex_dout, 'h7FFF);
    chk("t4_last_fw_addr", firewall_out_addr, 5);
    // selector updates with no table activity
    send(OP_SEL, TGT_REGEX, 0, 64'(SEL_FW));
    idle();
    chk("t5_sel_lat_a", output_selector, SEL_BOTH);
    @(negedge clk);
    chk("t5_sel_lat_b", output_selector, SEL_BOTH);
    @(negedge clk);
    chk("t5_sel_fw", output_selector, 2);
    send(OP_SEL, TGT_FW, 0, 64'(SEL_REGEX));
    idle();
    repeat (2) @(negedge clk);
    chk("t5_sel_regex", output_selector, 1);
    chk("t5_wc", write_count, 1031);
    // reset mid-clear with two commands queued
    send(OP_CLEAR, TGT_FW, 0, 64'h0);
    send(OP_WRITE, TGT_REGEX, 5, 64'h55);
    send(OP_WRITE, TGT_REGEX, 6, 64'h66);
    idle();
    for (int n = 0; n < 1000 && !(firewall_wr_en && firewall_out_addr == 100); n++) @(negedge clk);
    chk("t6_reached_100", firewall_out_addr, 100);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_fw_wr_en", firewall_wr_en, 0);
    chk("t6_fw_addr", firewall_out_addr, 0);
    chk("t6_fw_dout", firewall_dout, 0);
    chk("t6_rx_addr", regex_out_addr, 0);
    chk("t6_rx_dout", regex_dout, 0);
    chk("t6_selector", output_selector, 0);
    chk("t6_wc", write_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 1);
    exp_q.delete();
    wc_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_busy_after", busy, 0);
    chk("t6_wc_after", write_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rule_table_loader.md
Name: rule_table_loader

Overview:
Writer side of the packet filter's rule-table configuration port. Accepts table-update commands from the register/host side, queues them, and sequences them onto the regex table write port (15-bit data, 14-bit address) and the firewall table write port (64-bit data, 19-bit address). It also drives the 32-bit regex/firewall output selector. It sits between the AXI-Lite register block and the packet filter output stage.

Parameters:
REGEX_ADDR_WIDTH, 14, regex table address width
REGEX_DATA_WIDTH, 15, regex table entry width
REGEX_DEPTH, 16384, number of valid regex entries (clear range and range check)
FW_ADDR_WIDTH, 19, firewall table address width
FW_DATA_WIDTH, 64, firewall table entry width
FW_DEPTH, 512, number of valid firewall entries
CMD_FIFO_DEPTH_BITS, 2, log2 of command FIFO depth

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept
cmd_op  in  2  0=WRITE, 1=CLEAR, 2=SET_SEL, 3=reserved
cmd_target  in  1  0=regex, 1=firewall
cmd_addr  in  19  entry address; low bits are used for regex
cmd_data  in  64  entry data or selector value; low bits are used as needed
regex_dout  out  REGEX_DATA_WIDTH  regex table write data
regex_out_addr  out  REGEX_ADDR_WIDTH  regex table write address
regex_wr_en  out  1  regex write strobe
firewall_dout  out  FW_DATA_WIDTH  firewall table write data
firewall_out_addr  out  FW_ADDR_WIDTH  firewall table write address
firewall_wr_en  out  1  firewall write strobe
output_selector  out  32  0=both, 1=regex only, 2=firewall only
busy  out  1  work is pending or in progress
write_count  out  32  number of table writes issued
err  out  1  sticky error flag
err_clr  in  1  clears err

Behaviour:
- Reset values: all data, address and strobe outputs 0; output_selector 0; write_count 0; err 0; FSM in IDLE; FIFO empty.
- Handshake:
  - cmd_ready = !fifo_full.
  - A command is enqueued on a rising edge where cmd_valid && cmd_ready.
  - Held valid while not ready: nothing is lost and nothing is duplicated.
- FSM states: IDLE, WRITE, CLEAR, SEL.
  - IDLE: when the FIFO is non-empty, pop one command and go to the state given by cmd_op. Reserved op: set err and stay in IDLE.
  - WRITE:
    - Exactly one cycle with the target's wr_en high, carrying the addressed entry and data.
    - If addr >= the target's DEPTH: no strobe, set err.
    - Return to IDLE.
  - CLEAR:
    - Write 0 to every address 0..DEPTH-1 of the target.
    - One write per cycle, with the strobe held high for DEPTH consecutive cycles.
    - Address counter sized to the address width; terminate at DEPTH-1 with no wrap.
    - Return to IDLE.
  - SEL: load output_selector from cmd_data[31:0] and return to IDLE. No table strobe.
- Latency: a command enqueued at edge N produces its first strobe, or the selector update, visible after edge N+2. A back-to-back WRITE stream sustains one write every 2 cycles.
- Address and data outputs hold their last written value when the strobe is low. regex and firewall strobes are never high in the same cycle.
- The FIFO keeps accepting during CLEAR until full.
- write_count increments by 1 per strobe cycle and wraps at 2^32.
- busy = (state != IDLE) || !fifo_empty.
- err_clr and a new error in the same cycle: the error wins and err stays 1.
- Reset asserted mid-CLEAR or mid-queue:
  - All state returns to reset values immediately (asynchronously).
  - Queued commands are discarded.
  - Strobes drop in the same cycle.

Decomposition:
- Shared package:
  - op codes (OP_WRITE, OP_CLEAR, OP_SEL)
  - target codes (TGT_REGEX, TGT_FW)
  - selector encodings (SEL_BOTH, SEL_REGEX, SEL_FW)
  - FSM state enum
- One sub-module: the existing fallthrough_small_fifo, used as the command queue (width 2+1+19+64).

Test Plan:
- Reset, then WRITE regex addr 0x0123 data 0x5A5A: regex_wr_en high exactly 1 cycle, 2 cycles after accept; regex_out_addr=0x0123; regex_dout=0x5A5A; write_count=1; firewall_wr_en stays 0.
- WRITE firewall addr 600 with FW_DEPTH=512: no strobe, err=1; err_clr asserted alone: err=0 the next cycle.
- CLEAR firewall with FW_DEPTH=512:
  - Expect 512 consecutive firewall_wr_en cycles, addresses 0..511, data 0.
  - write_count +512; busy drops after the last write.
- Push 6 WRITE commands back-to-back with FIFO depth 4:
  - cmd_ready deasserts when the FIFO is full.
  - All 6 are written in order with correct addr/data; none are dropped or duplicated.
- SET_SEL data 2 followed by SET_SEL data 1: output_selector=2, then 1; no table strobes; write_count unchanged.
- Assert axi_aresetn=0 during CLEAR at address 100 with 2 commands queued:
  - Strobes and all outputs go to 0 immediately.
  - After release, busy=0 and no further writes occur.
